aes_encrypt_iter: RTL and testbench

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_encrypt_iter_pkg.sv | 69 ++++++
 rtl/aes_encrypt_iter_round.sv | 48 ++++
 rtl/aes_encrypt_iter.sv | 104 ++++++++++
 tb/tb_aes_encrypt_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES definitions: FSM encoding, round count, S-box and the
// SubWord / KeyExpansion helpers used by the encryption datapath.
package aes_encrypt_iter_pkg;

  localparam int AES_NR = 10;
  localparam int ROUND_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; the shifted-out bit folds back as 0x1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box substitution of all four bytes of a 32-bit word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // AES-128 key schedule packed so round key r sits at [128*r +: 128],
  // with word 4r in the most significant bits of that slice.
  function automatic logic [128*(AES_NR+1)-1:0] key_expansion(input logic [127:0] key);
    logic [31:0] w [4*(AES_NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [128*(AES_NR+1)-1:0] result;
    result = '0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) begin
      w[i] = key[127-32*i -: 32];
    end
    for (int i = 4; i < 4*(AES_NR+1); i++) begin
      t = w[i-1];
      if ((i % 4) == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(AES_NR+1); i++) begin
      result[128*(i/4) + 96 - 32*(i%4) +: 32] = w[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. The last round skips MixColumns when final_round is high.
module aes_round
  import aes_encrypt_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;

  // Column mix with fixed coefficients {02,03,01,01} rotated per row.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the block is row i%4, column i/4; each column is one SubWord.
  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    mix_cols   = '0;
    for (int c = 0; c < 4; c++) begin
      sub_bytes[127-32*c -: 32] = sub_word(state[127-32*c -: 32]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
    end
    next_state = (final_round ? shift_rows : mix_cols) ^ round_key;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready handshake on
// both sides. The expanded key is supplied externally and must stay stable
// while a block is in flight.
module aes_encrypt_iter
  import aes_encrypt_iter_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            plaintext,
  input  logic [128*(NR+1)-1:0]   full_key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            ciphertext,
  output logic                    busy
);

  aes_fsm_e                 fsm_q;
  aes_fsm_e                 fsm_d;
  logic [ROUND_CNT_W-1:0]   round_q;
  logic [ROUND_CNT_W-1:0]   round_d;
  logic [127:0]             state_q;
  logic [127:0]             state_d;
  logic [127:0]             round_key;
  logic [127:0]             round_out;
  logic                     final_round;

  assign final_round = (round_q == ROUND_CNT_W'(NR));
  assign ciphertext  = state_q;

  // Pick the round key addressed by the round counter.
  always_comb begin
    round_key = full_key[127:0];
    for (int r = 1; r <= NR; r++) begin
      if (round_q == ROUND_CNT_W'(r)) begin
        round_key = full_key[128*r +: 128];
      end
    end
  end

  aes_round u_round (
    .state       (state_q),
    .round_key   (round_key),
    .final_round (final_round),
    .next_state  (round_out)
  );

  // Next-state, datapath update and handshake outputs for IDLE/ROUND/DONE.
  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (fsm_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = rst_n;
        if (in_valid && in_ready) begin
          state_d = plaintext ^ full_key[127:0];
          round_d = ROUND_CNT_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (final_round) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + ROUND_CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset that drops any block in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using the FIPS-197 known-answer vectors.
module tb_aes_encrypt_iter;
  import aes_encrypt_iter_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  plaintext = '0;
  logic [1407:0] full_key = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  ciphertext;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [1407:0] ek_b;
  logic [1407:0] ek_c;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .full_key   (full_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, then follow it round by round; out_valid must first be
  // seen high after the 10th edge following the accept edge.
  task automatic apply_stimulus(input string tag, input logic [127:0] pt, input logic [1407:0] key, input bit noise);
    int waited;
    waited = 0;
    plaintext = pt;
    full_key  = key;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check_output({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_output({tag, "_busy"}, 128'(busy), 128'd1);
    for (int k = 1; k <= 10; k++) begin
      if (noise) begin
        in_valid  = 1'b1;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      step();
      check_output($sformatf("%s_out_valid_e%0d", tag, k), 128'(out_valid), 128'(k == 10));
      if (k == 5) check_output({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    plaintext = pt;
  endtask

  // Check the ciphertext, hold it under backpressure, then release it.
  task automatic drain(input string tag, input logic [127:0] expected, input int hold);
    check_output({tag, "_ct"}, ciphertext, expected);
    for (int i = 0; i < hold; i++) begin
      step();
      check_output($sformatf("%s_hold%0d_ct", tag, i), ciphertext, expected);
      check_output($sformatf("%s_hold%0d_valid", tag, i), 128'(out_valid), 128'd1);
      check_output($sformatf("%s_hold%0d_in_ready", tag, i), 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output({tag, "_exit_valid"}, 128'(out_valid), 128'd0);
    check_output({tag, "_exit_in_ready"}, 128'(in_ready), 128'd1);
    check_output({tag, "_exit_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    logic [127:0]  b2b_pt  [3];
    logic [1407:0] b2b_key [3];
    logic [127:0]  b2b_ct  [3];
    int blk;
    int accepts;
    int last_acc;
    int cyc;
    bit reload;
    bit seen_valid;

    ek_b = key_expansion(KEY_B);
    ek_c = key_expansion(KEY_C);

    // Reset: outputs idle, in_ready held low while rst_n is low.
    rst_n = 1'b0;
    step();
    step();
    check_output("rst_in_ready_low", 128'(in_ready), 128'd0);
    check_output("rst_out_valid", 128'(out_valid), 128'd0);
    check_output("rst_busy", 128'(busy), 128'd0);
    check_output("rst_ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check_output("rst_in_ready_release", 128'(in_ready), 128'd1);

    // FIPS-197 Appendix B, with in_valid/plaintext noise while busy.
    apply_stimulus("appb", PT_B, ek_b, 1'b1);
    drain("appb", CT_B, 0);

    // FIPS-197 Appendix C.1 with five cycles of backpressure.
    apply_stimulus("appc", PT_C, ek_c, 1'b0);
    drain("appc", CT_C, 5);

    // Three back-to-back blocks with in_valid held high throughout.
    b2b_pt[0] = PT_B;  b2b_key[0] = ek_b;  b2b_ct[0] = CT_B;
    b2b_pt[1] = PT_C;  b2b_key[1] = ek_c;  b2b_ct[1] = CT_C;
    b2b_pt[2] = PT_B;  b2b_key[2] = ek_b;  b2b_ct[2] = CT_B;
    blk = 0;
    accepts = 0;
    last_acc = 0;
    cyc = 0;
    reload = 1'b0;
    plaintext = b2b_pt[0];
    full_key  = b2b_key[0];
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (blk < 3 && cyc < 100) begin
      if (in_valid && in_ready) begin
        if (accepts > 0) begin
          check_output($sformatf("b2b_spacing%0d", accepts), 128'(cyc - last_acc >= 12), 128'd1);
        end
        last_acc = cyc;
        accepts++;
      end
      if (out_valid) begin
        check_output($sformatf("b2b_ct%0d", blk), ciphertext, b2b_ct[blk]);
        blk++;
        reload = 1'b1;
      end
      step();
      cyc++;
      if (reload && blk < 3) begin
        plaintext = b2b_pt[blk];
        full_key  = b2b_key[blk];
      end
      reload = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("b2b_blocks_done", 128'(blk), 128'd3);
    check_output("b2b_accepts", 128'(accepts), 128'd3);

    // Reset while round 5 is pending: the block is dropped.
    plaintext = PT_B;
    full_key  = ek_b;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    check_output("midrst_in_ready_low", 128'(in_ready), 128'd0);
    check_output("midrst_busy", 128'(busy), 128'd0);
    check_output("midrst_ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check_output("midrst_in_ready", 128'(in_ready), 128'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check_output("midrst_no_valid", 128'(seen_valid), 128'd0);
    apply_stimulus("postrst", PT_C, ek_c, 1'b0);
    drain("postrst", CT_C, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
